ram_port_a_burst_ctrl: RTL and testbench

- Burst sequencer that drives port A of the team's dual-port RAM in the clk_A domain.
- Accepts burst requests (write or read, start address, length) on a valid/ready interface.
- Streams write data into the RAM. Collects registered read data into a small response FIFO that returns it on a valid/ready stream.
- Absorbs the RAM's one-cycle registered read latency and applies backpressure so no read beat is ever lost.

---
 rtl/rpa_pkg.sv | 19 +
 rtl/rpa_resp_fifo.sv | 50 +++++
 rtl/ram_port_a_burst_ctrl.sv | 130 +++++++++++++
 tb/tb_ram_port_a_burst_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rpa_pkg.sv
// rtl/rpa_pkg.sv - shared types and constants for the port-A burst sequencer
package rpa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN
    } rpa_state_e;

    localparam int RESP_DEPTH     = 4;
    localparam int RPA_DATA_WIDTH = 8;

    typedef struct packed {
        logic                      last;
        logic [RPA_DATA_WIDTH-1:0] data;
    } resp_entry_t;

endpackage

// File: rtl/rpa_resp_fifo.sv
// rtl/rpa_resp_fifo.sv - synchronous response FIFO with occupancy count
module rpa_resp_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_push    = push_i && (count_q != CNT_W'(DEPTH));
    assign do_pop     = pop_i && !empty_o;

    // Storage is cleared too so the read data output is zero straight out of reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/ram_port_a_burst_ctrl.sv
// rtl/ram_port_a_burst_ctrl.sv - burst sequencer driving port A of the dual-port RAM
module ram_port_a_burst_ctrl
    import rpa_pkg::*;
#(
    parameter int DATA_WIDTH = RPA_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk_A,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  ram_we_A,
    output logic [ADDR_WIDTH-1:0] ram_address_A,
    output logic [DATA_WIDTH-1:0] ram_data_in_A,
    input  logic [DATA_WIDTH-1:0] ram_data_out_A
);

    localparam int                    CNT_W     = $clog2(RESP_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    rpa_state_e            state_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q, addr_inc;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic                  p1_q, p2_q, last1_q, last2_q;
    logic                  ram_we_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_din_q;
    logic [CNT_W-1:0]      resp_count;
    logic                  fifo_empty, wr_fire, issue, pop;
    resp_entry_t           push_entry, head_entry;

    assign req_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign wr_ready      = (state_q == ST_WRITE);
    assign wr_fire       = wr_ready && wr_valid;
    assign ram_we_A      = ram_we_q;
    assign ram_address_A = ram_addr_q;
    assign ram_data_in_A = ram_din_q;
    assign addr_inc      = (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + ADDR_WIDTH'(1);

    // Beats still in the RAM pipeline hold a FIFO slot, so a push can never find it full.
    assign issue = (state_q == ST_READ) &&
                   ((int'(resp_count) + int'(p1_q) + int'(p2_q)) < RESP_DEPTH);

    assign push_entry = '{last: last2_q, data: ram_data_out_A};
    assign rd_valid   = !fifo_empty;
    assign rd_data    = head_entry.data;
    assign rd_last    = head_entry.last;
    assign pop        = rd_valid && rd_ready;

    always_ff @(posedge clk_A or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            p1_q        <= 1'b0;
            p2_q        <= 1'b0;
            last1_q     <= 1'b0;
            last2_q     <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
        end else begin
            p1_q     <= issue;
            p2_q     <= p1_q;
            last2_q  <= last1_q;
            ram_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        cur_addr_q  <= req_addr;
                        remaining_q <= req_len;
                        state_q     <= req_write ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (wr_fire) begin
                        ram_we_q    <= 1'b1;
                        ram_addr_q  <= cur_addr_q;
                        ram_din_q   <= wr_data;
                        cur_addr_q  <= addr_inc;
                        remaining_q <= remaining_q - LEN_WIDTH'(1);
                        if (remaining_q == '0) state_q <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        ram_addr_q  <= cur_addr_q;
                        last1_q     <= (remaining_q == '0);
                        cur_addr_q  <= addr_inc;
                        remaining_q <= remaining_q - LEN_WIDTH'(1);
                        if (remaining_q == '0) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!p1_q && !p2_q && fifo_empty) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    rpa_resp_fifo #(
        .WIDTH(DATA_WIDTH + 1),
        .DEPTH(RESP_DEPTH)
    ) u_resp_fifo (
        .clk_i      (clk_A),
        .reset_i    (reset),
        .push_i     (p2_q),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .pop_data_o (head_entry),
        .empty_o    (fifo_empty),
        .count_o    (resp_count)
    );

endmodule

// File: tb/tb_ram_port_a_burst_ctrl.sv
// tb/tb_ram_port_a_burst_ctrl.sv - directed self-checking bench for ram_port_a_burst_ctrl
module tb_ram_port_a_burst_ctrl;

    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int AW = 2;
    localparam int LW = 4;

    logic          clk_A, reset;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready, rd_last, busy;
    logic [DW-1:0] rd_data;
    logic          ram_we_A;
    logic [AW-1:0] ram_address_A;
    logic [DW-1:0] ram_data_in_A, ram_data_out_A;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            checks, errors, we_pulses, max_occ;

    ram_port_a_burst_ctrl #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
    ) dut (
        .clk_A(clk_A), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy),
        .ram_we_A(ram_we_A), .ram_address_A(ram_address_A),
        .ram_data_in_A(ram_data_in_A), .ram_data_out_A(ram_data_out_A)
    );

    // Port A of the RAM: write commits and read data registers on the same edge.
    always @(posedge clk_A or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            ram_data_out_A <= '0;
        end else begin
            if (ram_we_A) mem[ram_address_A] <= ram_data_in_A;
            ram_data_out_A <= mem[ram_address_A];
        end
    end

    initial clk_A = 1'b0;
    always #5 clk_A = ~clk_A;

    always @(negedge clk_A) begin
        if (ram_we_A) we_pulses++;
        if (int'(dut.resp_count) > max_occ) max_occ = int'(dut.resp_count);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_A);
        #1;
    endtask

    task automatic send_req(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] len);
        int n = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_len   = len;
        while (!req_ready && n < 50) begin step(); n++; end
        check("req_ready", 32'(req_ready), 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic write_beat(input logic [DW-1:0] d);
        int n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        while (!wr_ready && n < 50) begin step(); n++; end
        check("wr_ready", 32'(wr_ready), 1);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic read_collect(input int n);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (!rd_valid && w < 50) begin step(); w++; end
            check($sformatf("rd_valid[%0d]", i), 32'(rd_valid), 1);
            check($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(exp_q[i]));
            check($sformatf("rd_last[%0d]", i), 32'(rd_last), 32'(i == n - 1));
            step();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin step(); n++; end
        check("idle", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; we_pulses = 0; max_occ = 0;
        reset = 1'b1;
        req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
        wr_valid = 0; wr_data = '0; rd_ready = 0;
        step(); step();
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_we", 32'(ram_we_A), 0);
        reset = 1'b0;
        step();

        // 1: write A1..A3 to addresses 1..3
        we_pulses = 0;
        send_req(1'b1, 2'd1, 4'd2);
        write_beat(8'hA1);
        write_beat(8'hA2);
        write_beat(8'hA3);
        check("t1_busy_done", 32'(busy), 0);
        step(); step(); step();
        check("t1_we_pulses", 32'(we_pulses), 3);
        check("t1_mem1", 32'(mem[1]), 'hA1);
        check("t1_mem2", 32'(mem[2]), 'hA2);
        check("t1_mem3", 32'(mem[3]), 'hA3);

        // 2: read back with rd_ready high, checking first-beat latency
        rd_ready = 1'b1;
        send_req(1'b0, 2'd1, 4'd2);
        check("t2_valid_e0", 32'(rd_valid), 0);
        step();
        check("t2_valid_e1", 32'(rd_valid), 0);
        step();
        check("t2_valid_e2", 32'(rd_valid), 0);
        step();
        check("t2_valid_e3", 32'(rd_valid), 1);
        exp_q.delete();
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
        read_collect(3);
        wait_idle();

        // 3: six-beat read under backpressure, wrapping 3 -> 0
        rd_ready = 1'b0;
        max_occ = 0;
        send_req(1'b0, 2'd1, 4'd5);
        repeat (20) step();
        check("t3_max_occ", 32'(max_occ), 4);
        check("t3_busy_held", 32'(busy), 1);
        rd_ready = 1'b1;
        exp_q.delete();
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
        exp_q.push_back(8'h00); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
        read_collect(6);
        wait_idle();

        // 4: write wrapping from address 3 to 0
        send_req(1'b1, 2'd3, 4'd1);
        write_beat(8'hB3);
        write_beat(8'hB0);
        step(); step();
        check("t4_mem3", 32'(mem[3]), 'hB3);
        check("t4_mem0", 32'(mem[0]), 'hB0);

        // 6: request held through a write burst
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd2; req_len = 4'd1;
        check("t6_ready_idle", 32'(req_ready), 1);
        step();
        req_write = 1'b0; req_addr = 2'd2; req_len = 4'd0;
        check("t6_ready_w0", 32'(req_ready), 0);
        write_beat(8'hC2);
        check("t6_ready_w1", 32'(req_ready), 0);
        write_beat(8'hC3);
        check("t6_ready_back", 32'(req_ready), 1);
        step();
        check("t6_busy_second", 32'(busy), 1);
        check("t6_ready_second", 32'(req_ready), 0);
        req_valid = 1'b0;
        rd_ready = 1'b1;
        exp_q.delete();
        exp_q.push_back(8'hC2);
        read_collect(1);
        wait_idle();

        // 5: reset in the middle of a stalled read burst
        rd_ready = 1'b0;
        send_req(1'b0, 2'd0, 4'd3);
        repeat (4) step();
        reset = 1'b1;
        #1;
        check("t5_rd_valid", 32'(rd_valid), 0);
        check("t5_rd_last", 32'(rd_last), 0);
        check("t5_rd_data", 32'(rd_data), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_wr_ready", 32'(wr_ready), 0);
        check("t5_we", 32'(ram_we_A), 0);
        check("t5_addr", 32'(ram_address_A), 0);
        check("t5_din", 32'(ram_data_in_A), 0);
        check("t5_req_ready", 32'(req_ready), 1);
        check("t5_fifo_count", 32'(dut.resp_count), 0);
        step();
        reset = 1'b0;
        step();
        check("t5_ready_after", 32'(req_ready), 1);
        rd_ready = 1'b1;
        send_req(1'b0, 2'd0, 4'd0);
        exp_q.delete();
        exp_q.push_back(8'h00);
        read_collect(1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
